// File: rtl/prio_enc_if.sv
// Stream bundle for prio_encoder_pipe: request vector in, encoded index beats out.
// out_count exists only when PRIO_ENC_POPCOUNT_EN is defined.
interface prio_enc_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_scan;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_any;
  logic             out_last;
`ifdef PRIO_ENC_POPCOUNT_EN
  logic [CNT_W-1:0] out_count;
`endif

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_scan, out_ready,
    input  in_ready, out_valid, out_idx, out_any, out_last
`ifdef PRIO_ENC_POPCOUNT_EN
    , input out_count
`endif
  );

  // Encoder side
  modport slave (
    input  in_valid, in_data, in_scan, out_ready,
    output in_ready, out_valid, out_idx, out_any, out_last
`ifdef PRIO_ENC_POPCOUNT_EN
    , output out_count
`endif
  );
endinterface

// File: rtl/prio_encoder_pipe.sv
// Registered priority encoder with valid/ready streams. Single mode emits the
// highest set bit; scan mode emits every set bit MSB first, one beat per handshake.
// Optional macro PRIO_ENC_POPCOUNT_EN adds a registered population count output.
module prio_encoder_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  prio_enc_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] residue_q, residue_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_any_q, out_any_d;
  logic             out_last_q, out_last_d;
`ifdef PRIO_ENC_POPCOUNT_EN
  logic [CNT_W-1:0] out_count_q, out_count_d;
`endif

  logic             in_ready_c;
  logic             accept_c;
  logic             out_hs_c;
  logic [WIDTH-1:0] src_c;
  logic [IDX_W-1:0] src_idx_c;
  logic [WIDTH-1:0] src_rest_c;

  // Index of the highest set bit, 0 for an all-zero vector
  function automatic logic [IDX_W-1:0] hi_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Vector with the bit at position idx cleared
  function automatic logic [WIDTH-1:0] clr_bit(input logic [WIDTH-1:0] v,
                                               input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r = v;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (IDX_W'(i) == idx) r[i] = 1'b0;
    end
    return r;
  endfunction

`ifdef PRIO_ENC_POPCOUNT_EN
  // Number of ones in the vector
  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r = r + CNT_W'(v[i]);
    end
    return r;
  endfunction
`endif

  // Handshake decode; in_ready rises in the final-beat cycle so no bubble occurs
  always_comb begin
    in_ready_c = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    accept_c   = bus.in_valid && in_ready_c;
    out_hs_c   = out_valid_q && bus.out_ready;
    src_c      = accept_c ? bus.in_data : residue_q;
    src_idx_c  = hi_idx(src_c);
    src_rest_c = clr_bit(src_c, src_idx_c);
  end

  // Next-state and output beat selection
  always_comb begin
    state_d     = state_q;
    residue_d   = residue_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_any_d   = out_any_q;
    out_last_d  = out_last_q;
`ifdef PRIO_ENC_POPCOUNT_EN
    out_count_d = out_count_q;
`endif
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_idx_d   = src_idx_c;
      out_any_d   = |bus.in_data;
`ifdef PRIO_ENC_POPCOUNT_EN
      out_count_d = popcnt(bus.in_data);
`endif
      if (bus.in_scan && (src_rest_c != '0)) begin
        residue_d  = src_rest_c;
        out_last_d = 1'b0;
        state_d    = SCAN;
      end else begin
        residue_d  = '0;
        out_last_d = 1'b1;
        state_d    = IDLE;
      end
    end else if ((state_q == SCAN) && out_hs_c) begin
      out_idx_d  = src_idx_c;
      residue_d  = src_rest_c;
      out_last_d = (src_rest_c == '0);
      state_d    = (src_rest_c == '0) ? IDLE : SCAN;
    end else if (out_hs_c) begin
      out_valid_d = 1'b0;
    end
  end

  // State, residue and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      residue_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_any_q   <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef PRIO_ENC_POPCOUNT_EN
      out_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      residue_q   <= residue_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_any_q   <= out_any_d;
      out_last_q  <= out_last_d;
`ifdef PRIO_ENC_POPCOUNT_EN
      out_count_q <= out_count_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_any   = out_any_q;
  assign bus.out_last  = out_last_q;
`ifdef PRIO_ENC_POPCOUNT_EN
  assign bus.out_count = out_count_q;
`endif
endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe at WIDTH=8 and WIDTH=5 against a beat-queue model.
module tb_prio_encoder_pipe;
  logic clk;
  logic rst_n;

  typedef struct {
    int idx;
    bit any;
    bit last;
    int cnt;
  } beat_t;

  beat_t q8[$];
  beat_t q5[$];
  int    total;
  int    bad;

  prio_enc_if #(.WIDTH(8)) b8 ();
  prio_enc_if #(.WIDTH(5)) b5 ();

  prio_encoder_pipe #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  prio_encoder_pipe #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats for one accepted vector: set-bit indices listed MSB first
  task automatic push_beats(input int sel, input logic [7:0] d, input bit sc, input int w);
    int    set_bits[$];
    beat_t b;
    for (int k = w - 1; k >= 0; k--) begin
      if (((d >> k) & 8'h01) != 8'h00) set_bits.push_back(k);
    end
    if (set_bits.size() == 0) begin
      b = '{idx: 0, any: 1'b0, last: 1'b1, cnt: 0};
      if (sel == 0) q8.push_back(b); else q5.push_back(b);
    end else if (!sc) begin
      b = '{idx: set_bits[0], any: 1'b1, last: 1'b1, cnt: set_bits.size()};
      if (sel == 0) q8.push_back(b); else q5.push_back(b);
    end else begin
      foreach (set_bits[j]) begin
        b = '{idx: set_bits[j], any: 1'b1, last: (j == set_bits.size() - 1), cnt: set_bits.size()};
        if (sel == 0) q8.push_back(b); else q5.push_back(b);
      end
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input int sel, input bit v, input logic [7:0] d, input bit sc, input bit r);
    logic [31:0] ov, ir, oi, oa, ol, oc;
    beat_t f;
    int    n;
    bit    exp_ready, acc, hs;
    @(negedge clk);
    if (sel == 0) begin
      b8.in_valid = v; b8.in_data = d; b8.in_scan = sc; b8.out_ready = r;
    end else begin
      b5.in_valid = v; b5.in_data = d[4:0]; b5.in_scan = sc; b5.out_ready = r;
    end
    #1;
    oc = '0;
    if (sel == 0) begin
      ov = 32'(b8.out_valid); ir = 32'(b8.in_ready); oi = 32'(b8.out_idx);
      oa = 32'(b8.out_any); ol = 32'(b8.out_last);
`ifdef PRIO_ENC_POPCOUNT_EN
      oc = 32'(b8.out_count);
`endif
      n = q8.size();
      if (n != 0) f = q8[0];
    end else begin
      ov = 32'(b5.out_valid); ir = 32'(b5.in_ready); oi = 32'(b5.out_idx);
      oa = 32'(b5.out_any); ol = 32'(b5.out_last);
`ifdef PRIO_ENC_POPCOUNT_EN
      oc = 32'(b5.out_count);
`endif
      n = q5.size();
      if (n != 0) f = q5[0];
    end
    exp_ready = (n == 0) || (n == 1 && r);
    chk("out_valid", ov, 32'(n != 0));
    chk("in_ready", ir, 32'(exp_ready));
    if (n != 0) begin
      chk("out_idx", oi, 32'(f.idx));
      chk("out_any", oa, 32'(f.any));
      chk("out_last", ol, 32'(f.last));
`ifdef PRIO_ENC_POPCOUNT_EN
      chk("out_count", oc, 32'(f.cnt));
`endif
    end
    acc = v && exp_ready;
    hs  = (n != 0) && r;
    if (hs) begin
      if (sel == 0) void'(q8.pop_front()); else void'(q5.pop_front());
    end
    if (acc) push_beats(sel, d, sc, (sel == 0) ? 8 : 5);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_scan = 1'b0; b8.out_ready = 1'b0;
    b5.in_valid = 1'b0; b5.in_data = '0; b5.in_scan = 1'b0; b5.out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(b8.out_valid), 32'd0);
    chk("rst_idx", 32'(b8.out_idx), 32'd0);
    chk("rst_any", 32'(b8.out_any), 32'd0);
    chk("rst_last", 32'(b8.out_last), 32'd0);
`ifdef PRIO_ENC_POPCOUNT_EN
    chk("rst_count", 32'(b8.out_count), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(b8.in_ready), 32'd1);

    // Single mode back-to-back
    step(0, 1, 8'h80, 0, 1);
    step(0, 1, 8'h41, 0, 1);
    step(0, 1, 8'h01, 0, 1);
    step(0, 1, 8'h00, 0, 1);
    repeat (2) step(0, 0, 8'h00, 0, 1);

    // Scan 8'hA5 with a waiting vector taken on the last-beat edge
    step(0, 1, 8'hA5, 1, 1);
    repeat (4) step(0, 1, 8'h3C, 0, 1);
    repeat (2) step(0, 0, 8'h00, 0, 1);

    // Backpressure during scan
    step(0, 1, 8'h12, 1, 1);
    repeat (3) step(0, 0, 8'h00, 0, 0);
    repeat (3) step(0, 0, 8'h00, 0, 1);

    // Zero and single-bit scans
    step(0, 1, 8'h00, 1, 1);
    step(0, 1, 8'h08, 1, 1);
    repeat (2) step(0, 0, 8'h00, 0, 1);

    // Reset in the middle of a scan
    step(0, 1, 8'hFF, 1, 1);
    repeat (3) step(0, 0, 8'h00, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(b8.out_valid), 32'd0);
    chk("midrst_idx", 32'(b8.out_idx), 32'd0);
    chk("midrst_any", 32'(b8.out_any), 32'd0);
    chk("midrst_last", 32'(b8.out_last), 32'd0);
`ifdef PRIO_ENC_POPCOUNT_EN
    chk("midrst_count", 32'(b8.out_count), 32'd0);
`endif
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, 0, 8'h00, 0, 1);

    // Random traffic, WIDTH=8
    repeat (250) step(0, ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0));
    repeat (12) step(0, 0, 8'h00, 0, 1);

    // WIDTH=5: top bit, then random traffic
    step(1, 1, 8'h10, 0, 1);
    step(1, 0, 8'h00, 0, 1);
    step(1, 1, 8'h13, 1, 1);
    repeat (4) step(1, 0, 8'h00, 0, 1);
    repeat (200) step(1, ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0));
    repeat (8) step(1, 0, 8'h00, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
